// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: unit encoding, fixed per-unit latencies and slot-table entry type
// shared by the FP writeback-slot scheduler and its RAW checker.
package fp_sched_pkg;

  typedef enum logic [1:0] {
    FU_FADD  = 2'd0,
    FU_FMUL  = 2'd1,
    FU_R4    = 2'd2,
    FU_FMISC = 2'd3
  } fp_unit_t;

  // Cycles from issue to writeback, indexed by fp_unit_t.
  localparam int unsigned UNIT_LAT [4] = '{4, 3, 8, 1};
  localparam int unsigned MAX_UNIT_LAT = 8;

  typedef struct packed {
    logic     valid;
    fp_unit_t unit;
    logic     fp_wr;
    logic     int_wr;
  } fp_slot_t;

  function automatic int unsigned unit_lat(input fp_unit_t unit);
    return UNIT_LAT[unit];
  endfunction

endpackage

// File: rtl/fp_wb_slot_scheduler_if.sv
// fp_wb_slot_scheduler_if: issue-side request, kill vector and writeback-select bundle
// between ID/EXE issue (master) and the FP writeback-slot scheduler (slave).
interface fp_wb_slot_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_LAT    = 8
);
  import fp_sched_pkg::*;

  logic                          issue_valid;
  fp_unit_t                      issue_unit;
  logic [ADDR_WIDTH-1:0]         issue_rd;
  logic                          issue_fp_wr;
  logic                          issue_int_wr;
  logic [2:0][ADDR_WIDTH-1:0]    rs_addr;
  logic [2:0]                    rs_fp;
  logic [MAX_LAT-1:0]            kill_mask;
  logic                          issue_ready;
  logic                          wb_valid;
  fp_unit_t                      wb_unit;
  logic [ADDR_WIDTH-1:0]         wb_rd;
  logic                          wb_fp_wr;
  logic                          wb_int_wr;
  logic                          busy;

  modport master (
    output issue_valid, issue_unit, issue_rd, issue_fp_wr, issue_int_wr,
           rs_addr, rs_fp, kill_mask,
    input  issue_ready, wb_valid, wb_unit, wb_rd, wb_fp_wr, wb_int_wr, busy
  );

  modport slave (
    input  issue_valid, issue_unit, issue_rd, issue_fp_wr, issue_int_wr,
           rs_addr, rs_fp, kill_mask,
    output issue_ready, wb_valid, wb_unit, wb_rd, wb_fp_wr, wb_int_wr, busy
  );

endinterface

// File: rtl/fp_raw_check.sv
// fp_raw_check: three-source RAW compare against in-flight FP destinations.
// Define FP_WB_BYPASS_EN to exclude the retiring slot (regfile write-through covers it).
module fp_raw_check #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_LAT    = 8
) (
  input  logic [MAX_LAT-1:0]                 slot_wr,
  input  logic [MAX_LAT-1:0][ADDR_WIDTH-1:0] slot_rd,
  input  logic [2:0][ADDR_WIDTH-1:0]         rs_addr,
  input  logic [2:0]                         rs_fp,
  output logic                               hazard
);

  logic [MAX_LAT-1:0] live;

  always_comb begin
    live = slot_wr;
`ifdef FP_WB_BYPASS_EN
    live[0] = 1'b0;
`endif
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned k = 0; k < MAX_LAT; k++) begin
        if (rs_fp[i] && live[k] && (rs_addr[i] == slot_rd[k])) begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fp_wb_slot_scheduler.sv
// fp_wb_slot_scheduler: reserves a shared-writeback slot per FP op and interlocks RAW hazards.
// Optional macro FP_WB_BYPASS_EN (handled in fp_raw_check) drops slot 0 from the RAW compare.
module fp_wb_slot_scheduler
  import fp_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_LAT    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fp_wb_slot_scheduler_if.slave bus
);

  // A latency equal to MAX_LAT lands in the top slot; anything longer cannot be tracked.
  if (MAX_LAT < MAX_UNIT_LAT) begin : g_lat_check
    $error("fp_wb_slot_scheduler: MAX_LAT smaller than the longest UNIT_LAT entry");
  end

  fp_slot_t [MAX_LAT-1:0]                 slot_q, slot_d;
  logic     [MAX_LAT-1:0][ADDR_WIDTH-1:0] rd_q, rd_d;
  logic     [MAX_LAT-1:0]                 slot_valid;
  logic     [MAX_LAT-1:0]                 slot_wr;
  int unsigned                            lat;
  logic                                   conflict;
  logic                                   hazard;
  logic                                   ready;
  logic                                   accept;

  always_comb begin
    for (int unsigned k = 0; k < MAX_LAT; k++) begin
      slot_valid[k] = slot_q[k].valid;
      slot_wr[k]    = slot_q[k].valid & slot_q[k].fp_wr;
    end
  end

  fp_raw_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_LAT    (MAX_LAT)
  ) u_raw_check (
    .slot_wr (slot_wr),
    .slot_rd (rd_q),
    .rs_addr (bus.rs_addr),
    .rs_fp   (bus.rs_fp),
    .hazard  (hazard)
  );

  // Conflict looks at the pre-kill slot[L], which is what shifts into slot[L-1].
  always_comb begin
    lat      = unit_lat(bus.issue_unit);
    conflict = 1'b0;
    for (int unsigned k = 0; k < MAX_LAT; k++) begin
      if ((k == lat) && slot_valid[k]) begin
        conflict = 1'b1;
      end
    end
  end

  assign ready  = en & ~conflict & ~hazard;
  assign accept = bus.issue_valid & ready;

  always_comb begin
    slot_d = slot_q;
    rd_d   = rd_q;
    if (en) begin
      for (int unsigned k = 0; k + 1 < MAX_LAT; k++) begin
        if (bus.kill_mask[k+1]) begin
          slot_d[k] = '0;
          rd_d[k]   = '0;
        end else begin
          slot_d[k] = slot_q[k+1];
          rd_d[k]   = rd_q[k+1];
        end
      end
      slot_d[MAX_LAT-1] = '0;
      rd_d[MAX_LAT-1]   = '0;
    end else begin
      for (int unsigned k = 0; k < MAX_LAT; k++) begin
        if (bus.kill_mask[k]) begin
          slot_d[k] = '0;
          rd_d[k]   = '0;
        end
      end
    end
    // The new reservation overrides any kill aimed at the slot it lands in.
    if (accept) begin
      for (int unsigned k = 0; k < MAX_LAT; k++) begin
        if (k + 1 == lat) begin
          slot_d[k] = '{valid: 1'b1, unit: bus.issue_unit,
                        fp_wr: bus.issue_fp_wr, int_wr: bus.issue_int_wr};
          rd_d[k]   = bus.issue_rd;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      rd_q   <= '0;
    end else begin
      slot_q <= slot_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.issue_ready = ready;
  assign bus.wb_valid    = slot_q[0].valid;
  assign bus.wb_unit     = slot_q[0].valid ? slot_q[0].unit : FU_FADD;
  assign bus.wb_rd       = slot_q[0].valid ? rd_q[0] : '0;
  assign bus.wb_fp_wr    = slot_q[0].valid & slot_q[0].fp_wr;
  assign bus.wb_int_wr   = slot_q[0].valid & slot_q[0].int_wr;
  assign bus.busy        = |slot_valid;

endmodule

// File: tb/tb_fp_wb_slot_scheduler.sv
// tb_fp_wb_slot_scheduler: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a list-of-in-flight-ops model.
module tb_fp_wb_slot_scheduler;
  import fp_sched_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned ML = 8;
`ifdef FP_WB_BYPASS_EN
  localparam int FIRST_SLOT = 1;
`else
  localparam int FIRST_SLOT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  fp_wb_slot_scheduler_if #(.ADDR_WIDTH(AW), .MAX_LAT(ML)) ifc ();

  fp_wb_slot_scheduler #(.ADDR_WIDTH(AW), .MAX_LAT(ML)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             rem;
    fp_unit_t       unit;
    logic [AW-1:0]  rd;
    bit             fp_wr;
    bit             int_wr;
  } op_t;

  op_t inflight[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic int lat_of(input fp_unit_t u);
    case (u)
      FU_FADD: return 4;
      FU_FMUL: return 3;
      FU_R4:   return 8;
      default: return 1;
    endcase
  endfunction

  function automatic bit model_ready();
    int l;
    l = lat_of(ifc.issue_unit);
    if (!en) return 1'b0;
    foreach (inflight[j]) begin
      if (inflight[j].rem == l) return 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (ifc.rs_fp[i] && inflight[j].fp_wr && inflight[j].rem >= FIRST_SLOT &&
            inflight[j].rd == ifc.rs_addr[i]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // Model: each op counts down to its writeback cycle.
  always @(posedge clk or negedge rst) begin : model_update
    op_t nxt[$];
    op_t o;
    bit  acc;
    if (!rst) begin
      inflight.delete();
    end else begin
      nxt.delete();
      acc = ifc.issue_valid && model_ready();
      foreach (inflight[j]) begin
        o = inflight[j];
        if (ifc.kill_mask[o.rem]) continue;
        if (en) begin
          o.rem = o.rem - 1;
          if (o.rem < 0) continue;
        end
        nxt.push_back(o);
      end
      if (acc) begin
        o.rem    = lat_of(ifc.issue_unit) - 1;
        o.unit   = ifc.issue_unit;
        o.rd     = ifc.issue_rd;
        o.fp_wr  = ifc.issue_fp_wr;
        o.int_wr = ifc.issue_int_wr;
        nxt.push_back(o);
      end
      inflight = nxt;
    end
  end

  always @(negedge clk) begin : compare
    bit            ev, efp, eint;
    fp_unit_t      eu;
    logic [AW-1:0] erd;
    ev = 1'b0; efp = 1'b0; eint = 1'b0; eu = FU_FADD; erd = '0;
    foreach (inflight[j]) begin
      if (inflight[j].rem == 0) begin
        ev = 1'b1; eu = inflight[j].unit; erd = inflight[j].rd;
        efp = inflight[j].fp_wr; eint = inflight[j].int_wr;
      end
    end
    chk("issue_ready", 32'(ifc.issue_ready), 32'(model_ready()));
    chk("wb_valid",    32'(ifc.wb_valid),    32'(ev));
    chk("wb_unit",     32'(ifc.wb_unit),     32'(eu));
    chk("wb_rd",       32'(ifc.wb_rd),       32'(erd));
    chk("wb_fp_wr",    32'(ifc.wb_fp_wr),    32'(efp));
    chk("wb_int_wr",   32'(ifc.wb_int_wr),   32'(eint));
    chk("busy",        32'(ifc.busy),        32'(inflight.size() != 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.issue_valid  = 1'b0;
    ifc.issue_unit   = FU_FADD;
    ifc.issue_rd     = '0;
    ifc.issue_fp_wr  = 1'b0;
    ifc.issue_int_wr = 1'b0;
    ifc.rs_addr      = '0;
    ifc.rs_fp        = '0;
    ifc.kill_mask    = '0;
  endtask

  task automatic drain();
    idle();
    repeat (10) tick();
  endtask

  task automatic issue(input fp_unit_t u, input logic [AW-1:0] rd);
    idle();
    ifc.issue_valid = 1'b1;
    ifc.issue_unit  = u;
    ifc.issue_rd    = rd;
    ifc.issue_fp_wr = 1'b1;
  endtask

  initial begin
    idle();
    repeat (2) tick();
    chk("reset_busy",  32'(ifc.busy), 0);
    chk("reset_ready", 32'(ifc.issue_ready), 0);
    chk("reset_wb",    32'(ifc.wb_valid), 0);
    rst = 1'b1;
    en  = 1'b1;
    #1;
    chk("reset_ready_en", 32'(ifc.issue_ready), 1);
    tick();

    // FMUL latency 3
    issue(FU_FMUL, 5'd3);
    #1 chk("t1_ready", 32'(ifc.issue_ready), 1);
    tick(); idle();
    #1 chk("t1_wb_t1", 32'(ifc.wb_valid), 0);
    tick();
    #1 chk("t1_wb_t2", 32'(ifc.wb_valid), 0);
    tick();
    #1;
    chk("t1_wb_t3", 32'(ifc.wb_valid), 1);
    chk("t1_unit",  32'(ifc.wb_unit), 32'(FU_FMUL));
    chk("t1_rd",    32'(ifc.wb_rd), 3);
    tick();
    #1 chk("t1_wb_t4", 32'(ifc.wb_valid), 0);
    drain();

    // R4 then FADD colliding on the same writeback cycle
    issue(FU_R4, 5'd1);
    tick(); idle();
    repeat (3) tick();
    issue(FU_FADD, 5'd2);
    #1 chk("t2_conflict", 32'(ifc.issue_ready), 0);
    tick();
    #1 chk("t2_ready", 32'(ifc.issue_ready), 1);
    tick(); idle();
    tick();
    #1 chk("t2_wb7", 32'(ifc.wb_valid), 0);
    tick();
    #1 chk("t2_r4_unit", 32'(ifc.wb_unit), 32'(FU_R4));
    chk("t2_r4_rd", 32'(ifc.wb_rd), 1);
    tick();
    #1 chk("t2_fadd_unit", 32'(ifc.wb_unit), 32'(FU_FADD));
    chk("t2_fadd_rd", 32'(ifc.wb_rd), 2);
    drain();

    // RAW on an in-flight FADD destination
    issue(FU_FADD, 5'd7);
    tick(); idle();
    ifc.issue_unit = FU_FMUL;
    ifc.rs_addr[0] = 5'd7;
    ifc.rs_fp      = 3'b001;
    for (int c = 1; c <= 5; c++) begin
      #1 chk("t3_raw_ready", 32'(ifc.issue_ready), 32'(c >= 5 - FIRST_SLOT));
      tick();
    end
    drain();

    // Freeze with FMUL one cycle from writeback
    issue(FU_FMUL, 5'd4);
    tick(); idle();
    tick();
    en = 1'b0;
    repeat (3) begin
      #1;
      chk("t4_ready_frozen", 32'(ifc.issue_ready), 0);
      chk("t4_wb_frozen",    32'(ifc.wb_valid), 0);
      chk("t4_busy_frozen",  32'(ifc.busy), 1);
      tick();
    end
    en = 1'b1;
    #1 chk("t4_wb_pre", 32'(ifc.wb_valid), 0);
    tick();
    #1 chk("t4_wb", 32'(ifc.wb_valid), 1);
    chk("t4_rd", 32'(ifc.wb_rd), 4);
    tick();
    #1 chk("t4_wb_post", 32'(ifc.wb_valid), 0);
    drain();

    // Kill an R4 reservation in slot 5
    issue(FU_R4, 5'd5);
    tick(); idle();
    repeat (2) tick();
    ifc.kill_mask = 8'b0010_0000;
    #1 chk("t5_busy_pre", 32'(ifc.busy), 1);
    tick();
    ifc.kill_mask = '0;
    #1 chk("t5_busy_post", 32'(ifc.busy), 0);
    repeat (8) begin
      #1 chk("t5_no_wb", 32'(ifc.wb_valid), 0);
      tick();
    end

    // Async reset with three reservations outstanding
    issue(FU_R4, 5'd1);
    tick();
    issue(FU_FADD, 5'd2);
    #1 chk("t6_ready_fadd", 32'(ifc.issue_ready), 1);
    tick();
    issue(FU_FMISC, 5'd3);
    #1 chk("t6_ready_fmisc", 32'(ifc.issue_ready), 1);
    tick(); idle();
    #1 chk("t6_wb_before", 32'(ifc.wb_valid), 1);
    rst = 1'b0;
    #1;
    chk("t6_busy_rst", 32'(ifc.busy), 0);
    chk("t6_wb_rst",   32'(ifc.wb_valid), 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) begin
      #1 chk("t6_no_wb", 32'(ifc.wb_valid), 0);
      tick();
    end

    // Random traffic
    repeat (3000) begin
      en               = ($urandom_range(0, 9) != 0);
      ifc.issue_valid  = 1'($urandom_range(0, 1));
      ifc.issue_unit   = fp_unit_t'(2'($urandom_range(0, 3)));
      ifc.issue_rd     = AW'($urandom_range(0, 7));
      ifc.issue_fp_wr  = ($urandom_range(0, 3) != 0);
      ifc.issue_int_wr = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) ifc.rs_addr[i] = AW'($urandom_range(0, 7));
      ifc.rs_fp        = 3'($urandom_range(0, 7));
      ifc.kill_mask    = '0;
      if ($urandom_range(0, 15) == 0) ifc.kill_mask[$urandom_range(0, ML - 1)] = 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        #2 rst = 1'b1;
      end
      tick();
    end

    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
